control_sequencer: RTL and testbench

- Microcoded control unit for the 8-bit computer.
- Decodes the opcode held in the instruction register and steps through the T-states of each instruction.
- Drives the datapath control word, including the add/subtract select into the ALU.
- Captures the ALU carry and zero outputs into a flags register; JC and JZ consume those flags.

---
 rtl/control_sequencer_if.sv | 23 ++
 rtl/control_sequencer.sv | 151 +++++++++++++++
 tb/tb_control_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Handshake-free bundle between the instruction register/ALU and the control sequencer.
// The sequencer side uses the slave modport; whatever drives instr and the ALU flags uses master.
interface control_sequencer_if #(
  parameter int unsigned DataBits = 8
);
  logic [DataBits-1:0] instr;
  logic                carry_flag;
  logic                zero_flag;
  logic [15:0]         ctrl;
  logic [2:0]          step;
  logic [1:0]          flags;
  logic                halted;

  modport master (
    output instr, carry_flag, zero_flag,
    input  ctrl, step, flags, halted
  );

  modport slave (
    input  instr, carry_flag, zero_flag,
    output ctrl, step, flags, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit computer: T-state counter, opcode decode,
// control word generation, ALU flag capture and halt latch.
module control_sequencer #(
  parameter int unsigned DataBits = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_sequencer_if.slave   bus
);

  localparam int unsigned OpLsb = DataBits - 4;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  // Control word bits, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
  localparam logic [15:0] CwHlt = 16'h8000;
  localparam logic [15:0] CwMi  = 16'h4000;
  localparam logic [15:0] CwRi  = 16'h2000;
  localparam logic [15:0] CwRo  = 16'h1000;
  localparam logic [15:0] CwIo  = 16'h0800;
  localparam logic [15:0] CwIi  = 16'h0400;
  localparam logic [15:0] CwAi  = 16'h0200;
  localparam logic [15:0] CwAo  = 16'h0100;
  localparam logic [15:0] CwEo  = 16'h0080;
  localparam logic [15:0] CwSu  = 16'h0040;
  localparam logic [15:0] CwBi  = 16'h0020;
  localparam logic [15:0] CwOi  = 16'h0010;
  localparam logic [15:0] CwCe  = 16'h0008;
  localparam logic [15:0] CwCo  = 16'h0004;
  localparam logic [15:0] CwJ   = 16'h0002;
  localparam logic [15:0] CwFi  = 16'h0001;

  logic [2:0]  step_q, step_d;
  logic [1:0]  flags_q, flags_d;
  logic        halted_q, halted_d;
  logic [15:0] ctrl_c;
  logic [2:0]  last_step_c;
  logic [3:0]  opcode;
  logic        unused_instr_bits;

  assign opcode            = bus.instr[DataBits-1:OpLsb];
  assign unused_instr_bits = ^bus.instr[OpLsb-1:0];

  // Control word decode; held at zero during reset, only hlt once halted.
  always_comb begin
    ctrl_c = '0;
    if (!rst_n) begin
      ctrl_c = '0;
    end else if (halted_q) begin
      ctrl_c = CwHlt;
    end else begin
      unique case (step_q)
        T0: ctrl_c = CwCo | CwMi;
        T1: ctrl_c = CwRo | CwIi | CwCe;
        T2: begin
          case (opcode)
            OpLda, OpAdd, OpSub, OpSta: ctrl_c = CwIo | CwMi;
            OpLdi: ctrl_c = CwIo | CwAi;
            OpJmp: ctrl_c = CwIo | CwJ;
            OpJc:  ctrl_c = flags_q[1] ? (CwIo | CwJ) : 16'h0000;
            OpJz:  ctrl_c = flags_q[0] ? (CwIo | CwJ) : 16'h0000;
            OpOut: ctrl_c = CwAo | CwOi;
            OpHlt: ctrl_c = CwHlt;
            default: ctrl_c = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OpLda:        ctrl_c = CwRo | CwAi;
            OpAdd, OpSub: ctrl_c = CwRo | CwBi;
            OpSta:        ctrl_c = CwAo | CwRi;
            default:      ctrl_c = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OpAdd:   ctrl_c = CwEo | CwAi | CwFi;
            OpSub:   ctrl_c = CwEo | CwAi | CwSu | CwFi;
            default: ctrl_c = '0;
          endcase
        end
        default: ctrl_c = '0;
      endcase
    end
  end

  // Final T-state of each instruction; unlisted opcodes behave as NOP.
  always_comb begin
    last_step_c = T1;
    case (opcode)
      OpLda, OpSta:                       last_step_c = T3;
      OpAdd, OpSub:                       last_step_c = T4;
      OpLdi, OpJmp, OpJc, OpJz, OpOut,
      OpHlt:                              last_step_c = T2;
      default:                            last_step_c = T1;
    endcase
  end

  // Next-state: step advance/wrap, flag capture on fi, halt latch.
  always_comb begin
    step_d   = step_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == T2 && opcode == OpHlt) begin
        halted_d = 1'b1;
      end else if (step_q >= last_step_c) begin
        step_d = T0;
      end else begin
        step_d = step_q + 3'd1;
      end
      if (ctrl_c[0]) begin
        flags_d = {bus.carry_flag, bus.zero_flag};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= T0;
      flags_q  <= 2'b00;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  assign bus.ctrl   = ctrl_c;
  assign bus.step   = step_q;
  assign bus.flags  = flags_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction sequences push expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_control_sequencer;

  logic clk;
  logic rst_n;

  control_sequencer_if #(.DataBits(8)) bus ();

  control_sequencer #(.DataBits(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int          tag;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic [1:0]  flags;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tag_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the rising edge and record what that cycle must show.
  task automatic tick(input logic r, input logic [7:0] i, input logic c, input logic z,
                      input logic [15:0] ec, input logic [2:0] es, input logic [1:0] ef,
                      input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = r;
    bus.instr      = i;
    bus.carry_flag = c;
    bus.zero_flag  = z;
    tag_cnt++;
    e.tag    = tag_cnt;
    e.ctrl   = ec;
    e.step   = es;
    e.flags  = ef;
    e.halted = eh;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.ctrl !== e.ctrl || bus.step !== e.step || bus.flags !== e.flags ||
            bus.halted !== e.halted) begin
          failures++;
          $display("FAIL cycle%0d: got ctrl=%h step=%0d flags=%b halted=%b, want ctrl=%h step=%0d flags=%b halted=%b",
                   e.tag, bus.ctrl, bus.step, bus.flags, bus.halted,
                   e.ctrl, e.step, e.flags, e.halted);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.instr      = 8'h00;
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;

    // Reset state
    tick(0, 8'h00, 0, 0, 16'h0000, 0, 2'b00, 0);
    tick(0, 8'h00, 0, 0, 16'h0000, 0, 2'b00, 0);

    // LDA aborted by mid-instruction reset, then a full LDA
    tick(1, 8'h10, 0, 0, 16'h4004, 0, 2'b00, 0);
    tick(1, 8'h10, 0, 0, 16'h1408, 1, 2'b00, 0);
    tick(1, 8'h10, 0, 0, 16'h4800, 2, 2'b00, 0);
    tick(0, 8'h10, 0, 0, 16'h0000, 0, 2'b00, 0);
    tick(1, 8'h10, 0, 0, 16'h4004, 0, 2'b00, 0);
    tick(1, 8'h10, 0, 0, 16'h1408, 1, 2'b00, 0);
    tick(1, 8'h10, 0, 0, 16'h4800, 2, 2'b00, 0);
    tick(1, 8'h10, 0, 0, 16'h1200, 3, 2'b00, 0);

    // ADD 2E: carry=1 zero=0 at T4 -> flags 10
    tick(1, 8'h2E, 0, 0, 16'h4004, 0, 2'b00, 0);
    tick(1, 8'h2E, 0, 0, 16'h1408, 1, 2'b00, 0);
    tick(1, 8'h2E, 0, 0, 16'h4800, 2, 2'b00, 0);
    tick(1, 8'h2E, 0, 0, 16'h1020, 3, 2'b00, 0);
    tick(1, 8'h2E, 1, 0, 16'h0281, 4, 2'b00, 0);

    // SUB 3C: carry=1 zero=1 -> flags 11; then JZ taken
    tick(1, 8'h3C, 0, 0, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h3C, 0, 0, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h3C, 0, 0, 16'h4800, 2, 2'b10, 0);
    tick(1, 8'h3C, 0, 0, 16'h1020, 3, 2'b10, 0);
    tick(1, 8'h3C, 1, 1, 16'h02C1, 4, 2'b10, 0);
    tick(1, 8'h85, 0, 0, 16'h4004, 0, 2'b11, 0);
    tick(1, 8'h85, 0, 0, 16'h1408, 1, 2'b11, 0);
    tick(1, 8'h85, 0, 0, 16'h0802, 2, 2'b11, 0);

    // SUB with carry=1 zero=0 -> flags 10; JZ not taken, still 3 steps
    tick(1, 8'h31, 0, 0, 16'h4004, 0, 2'b11, 0);
    tick(1, 8'h31, 0, 0, 16'h1408, 1, 2'b11, 0);
    tick(1, 8'h31, 0, 0, 16'h4800, 2, 2'b11, 0);
    tick(1, 8'h31, 0, 0, 16'h1020, 3, 2'b11, 0);
    tick(1, 8'h31, 1, 0, 16'h02C1, 4, 2'b11, 0);
    tick(1, 8'h85, 0, 1, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h85, 0, 1, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h85, 0, 1, 16'h0000, 2, 2'b10, 0);

    // Flag retention across LDA/LDI/STA with conflicting live ALU flags, then JC taken
    tick(1, 8'h1F, 0, 1, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h1F, 0, 1, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h1F, 0, 1, 16'h4800, 2, 2'b10, 0);
    tick(1, 8'h1F, 0, 1, 16'h1200, 3, 2'b10, 0);
    tick(1, 8'h53, 0, 1, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h53, 0, 1, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h53, 0, 1, 16'h0A00, 2, 2'b10, 0);
    tick(1, 8'h4F, 0, 1, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h4F, 0, 1, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h4F, 0, 1, 16'h4800, 2, 2'b10, 0);
    tick(1, 8'h4F, 0, 1, 16'h2100, 3, 2'b10, 0);
    tick(1, 8'h70, 0, 1, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h70, 0, 1, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h70, 0, 1, 16'h0802, 2, 2'b10, 0);

    // OUT and JMP
    tick(1, 8'hE0, 0, 0, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'hE0, 0, 0, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'hE0, 0, 0, 16'h0110, 2, 2'b10, 0);
    tick(1, 8'h60, 0, 0, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h60, 0, 0, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h60, 0, 0, 16'h0802, 2, 2'b10, 0);

    // ADD with carry=0 zero=1 -> flags 01; JC not taken
    tick(1, 8'h20, 0, 0, 16'h4004, 0, 2'b10, 0);
    tick(1, 8'h20, 0, 0, 16'h1408, 1, 2'b10, 0);
    tick(1, 8'h20, 0, 0, 16'h4800, 2, 2'b10, 0);
    tick(1, 8'h20, 0, 0, 16'h1020, 3, 2'b10, 0);
    tick(1, 8'h20, 0, 1, 16'h0281, 4, 2'b10, 0);
    tick(1, 8'h70, 1, 0, 16'h4004, 0, 2'b01, 0);
    tick(1, 8'h70, 1, 0, 16'h1408, 1, 2'b01, 0);
    tick(1, 8'h70, 1, 0, 16'h0000, 2, 2'b01, 0);

    // Undefined opcode A0: step 0,1,0
    tick(1, 8'hA0, 0, 0, 16'h4004, 0, 2'b01, 0);
    tick(1, 8'hA0, 0, 0, 16'h1408, 1, 2'b01, 0);
    tick(1, 8'hA0, 0, 0, 16'h4004, 0, 2'b01, 0);
    tick(1, 8'hA0, 0, 0, 16'h1408, 1, 2'b01, 0);

    // HLT: stays halted at step 2 with live flags toggled, until reset
    tick(1, 8'hF0, 1, 1, 16'h4004, 0, 2'b01, 0);
    tick(1, 8'hF0, 1, 1, 16'h1408, 1, 2'b01, 0);
    tick(1, 8'hF0, 1, 1, 16'h8000, 2, 2'b01, 0);
    for (int k = 0; k < 20; k++) begin
      tick(1, (k % 2 == 0) ? 8'h2E : 8'hF0, 1, 1, 16'h8000, 2, 2'b01, 1);
    end
    tick(0, 8'hF0, 1, 1, 16'h0000, 0, 2'b00, 0);
    tick(1, 8'h00, 0, 0, 16'h4004, 0, 2'b00, 0);
    tick(1, 8'h00, 0, 0, 16'h1408, 1, 2'b00, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
